// File: rtl/eth_rx_fifo.sv
// Ethernet receive frame buffer: stores MAC bytes in a circular byte RAM, commits good frames
// through a descriptor FIFO and replays them byte-by-byte. Optional filter: RX_ADDR_FILTER_EN.
module eth_rx_fifo #(
  parameter int          ADDR_W      = 11,
  parameter int          LEN_DEPTH_W = 2,
  parameter logic [47:0] MAC_ADDR    = 48'h000000000000
) (
  input  logic        clk_mac,
  input  logic        rst,
  input  logic        rx_vld,
  input  logic [7:0]  rx_dat,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic        rx_err,
  output logic        out_vld,
  output logic [7:0]  out_dat,
  output logic        out_sof,
  output logic        out_eof,
  output logic [10:0] out_len,
  input  logic        out_ack,
  output logic [15:0] drop_cnt
);

  localparam int                DDEPTH  = 1 << LEN_DEPTH_W;
  localparam logic [10:0]       MAX_LEN = 11'd1518;
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} w_st_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_st_t;
  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [10:0]       len;
  } desc_t;

  logic [7:0]        mem [2**ADDR_W];
  desc_t             dq  [DDEPTH];
  w_st_t             w_st, w_nxt;
  r_st_t             r_st, r_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, start_ptr, start_nxt, free_ptr, rd_ptr, base, wa;
  logic [10:0]       wcnt, wcnt_nxt, c_new, rem, len_r;
  logic [LEN_DEPTH_W:0] dwp, drp;
  logic              d_empty, d_full, push, pop, ram_we, sof_r, filt_bad;
  logic [1:0]        drops;
  logic [7:0]        rd_q;

  assign d_empty = (dwp == drp);
  assign d_full  = (dwp[LEN_DEPTH_W] != drp[LEN_DEPTH_W]) &&
                   (dwp[LEN_DEPTH_W-1:0] == drp[LEN_DEPTH_W-1:0]);

  // A sof restarts at the current frame start, so a truncated frame's space is reused.
  always_comb begin
    base  = (w_st == W_STORE) ? start_ptr : wr_ptr;
    wa    = rx_sof ? base : wr_ptr;
    c_new = rx_sof ? 11'd1 : wcnt + 11'd1;
  end

`ifdef RX_ADDR_FILTER_EN
  logic       uc_ok, bc_ok, uc_now, bc_now, in_hdr;
  logic [2:0] bidx;
  logic [7:0] mac_b;

  always_comb begin
    bidx   = 3'(c_new - 11'd1);
    in_hdr = (c_new <= 11'd6);
    case (bidx)
      3'd0:    mac_b = MAC_ADDR[47:40];
      3'd1:    mac_b = MAC_ADDR[39:32];
      3'd2:    mac_b = MAC_ADDR[31:24];
      3'd3:    mac_b = MAC_ADDR[23:16];
      3'd4:    mac_b = MAC_ADDR[15:8];
      default: mac_b = MAC_ADDR[7:0];
    endcase
    uc_now   = (rx_sof | uc_ok) & (rx_dat == mac_b);
    bc_now   = (rx_sof | bc_ok) & (rx_dat == 8'hff);
    filt_bad = in_hdr && (bidx == 3'd5) && !uc_now && !bc_now;
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) begin
      uc_ok <= 1'b0;
      bc_ok <= 1'b0;
    end else if (rx_vld && in_hdr) begin
      uc_ok <= uc_now;
      bc_ok <= bc_now;
    end
  end
`else
  logic unused_mac;
  assign unused_mac = ^MAC_ADDR;
  assign filt_bad   = 1'b0;
`endif

  always_comb begin
    w_nxt      = w_st;
    wr_ptr_nxt = wr_ptr;
    start_nxt  = start_ptr;
    wcnt_nxt   = wcnt;
    ram_we     = 1'b0;
    push       = 1'b0;
    drops      = 2'd0;
    if (rx_vld) begin
      if (w_st == W_DROP) begin
        if (rx_eof) begin
          drops = 2'd1;
          w_nxt = W_IDLE;
        end
      end else if (rx_sof || w_st == W_STORE) begin
        ram_we    = 1'b1;
        start_nxt = base;
        if (rx_sof && w_st == W_STORE) drops = 2'd1;
        if ((wa + A_ONE == free_ptr) || (c_new > MAX_LEN) || filt_bad) begin
          wr_ptr_nxt = base;
          if (rx_eof) begin
            drops = drops + 2'd1;
            w_nxt = W_IDLE;
          end else begin
            w_nxt = W_DROP;
          end
        end else if (rx_eof) begin
          w_nxt = W_IDLE;
          // a pop in the same cycle frees a slot, so full-with-pop still commits
          if (rx_err || (d_full && !pop)) begin
            wr_ptr_nxt = base;
            drops      = drops + 2'd1;
          end else begin
            push       = 1'b1;
            wr_ptr_nxt = wa + A_ONE;
          end
        end else begin
          wr_ptr_nxt = wa + A_ONE;
          wcnt_nxt   = c_new;
          w_nxt      = W_STORE;
        end
      end
    end
  end

  always_comb begin
    r_nxt = r_st;
    pop   = 1'b0;
    case (r_st)
      R_IDLE:  if (!d_empty) r_nxt = R_FETCH;
      R_FETCH: r_nxt = R_SEND;
      R_SEND: begin
        if (out_ack) begin
          if (rem == 11'd1) begin
            pop   = 1'b1;
            r_nxt = R_IDLE;
          end else begin
            r_nxt = R_FETCH;
          end
        end
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) begin
      w_st      <= W_IDLE;
      r_st      <= R_IDLE;
      wr_ptr    <= '0;
      start_ptr <= '0;
      free_ptr  <= '0;
      rd_ptr    <= '0;
      wcnt      <= '0;
      rem       <= '0;
      len_r     <= '0;
      sof_r     <= 1'b0;
      dwp       <= '0;
      drp       <= '0;
      drop_cnt  <= '0;
    end else begin
      w_st      <= w_nxt;
      r_st      <= r_nxt;
      wr_ptr    <= wr_ptr_nxt;
      start_ptr <= start_nxt;
      wcnt      <= wcnt_nxt;
      if (drops != 2'd0)
        drop_cnt <= (drop_cnt > 16'hffff - 16'(drops)) ? 16'hffff : drop_cnt + 16'(drops);
      if (push) dwp <= dwp + 1'b1;
      if (pop) begin
        drp      <= drp + 1'b1;
        free_ptr <= rd_ptr + A_ONE;
      end
      if (r_st == R_IDLE && !d_empty) begin
        rd_ptr <= dq[drp[LEN_DEPTH_W-1:0]].start;
        rem    <= dq[drp[LEN_DEPTH_W-1:0]].len;
        len_r  <= dq[drp[LEN_DEPTH_W-1:0]].len;
        sof_r  <= 1'b1;
      end else if (r_st == R_SEND && out_ack && rem != 11'd1) begin
        rd_ptr <= rd_ptr + A_ONE;
        rem    <= rem - 11'd1;
        sof_r  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_mac) begin
    if (ram_we) mem[wa] <= rx_dat;
    if (push) dq[dwp[LEN_DEPTH_W-1:0]] <= '{start: base, len: c_new};
    if (r_st == R_FETCH) rd_q <= mem[rd_ptr];
  end

  assign out_vld = (r_st == R_SEND);
  assign out_dat = out_vld ? rd_q : 8'h00;
  assign out_sof = out_vld & sof_r;
  assign out_eof = out_vld & (rem == 11'd1);
  assign out_len = len_r;

endmodule

// File: tb/tb_eth_rx_fifo.sv
// Directed bench for eth_rx_fifo: frames in, captured byte stream checked against generated patterns.
module tb_eth_rx_fifo;
  logic        clk_mac = 1'b0;
  logic        rst = 1'b1;
  logic        rx_vld, rx_sof, rx_eof, rx_err, out_ack;
  logic [7:0]  rx_dat;
  logic        out_vld, out_sof, out_eof;
  logic [7:0]  out_dat;
  logic [10:0] out_len;
  logic [15:0] drop_cnt;

  localparam logic [47:0] BCAST = 48'hffffffffffff;

  typedef struct packed {
    logic [7:0]  d;
    logic        s;
    logic        e;
    logic [10:0] l;
  } cap_t;

  cap_t cap_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   lat;

  always #5 clk_mac = ~clk_mac;

  eth_rx_fifo #(.ADDR_W(11), .LEN_DEPTH_W(2), .MAC_ADDR(48'h020000000001)) dut (
    .clk_mac(clk_mac), .rst(rst),
    .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
    .out_vld(out_vld), .out_dat(out_dat), .out_sof(out_sof), .out_eof(out_eof),
    .out_len(out_len), .out_ack(out_ack), .drop_cnt(drop_cnt)
  );

  always @(negedge clk_mac)
    if (!rst && out_vld && out_ack) cap_q.push_back({out_dat, out_sof, out_eof, out_len});

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gen_byte(input logic [47:0] dest, input logic [7:0] seed, input int i);
    if (i < 6) return dest[8*(5-i) +: 8];
    return seed + 8'(i);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk_mac);
    #1;
  endtask

  task automatic send_frame(input int len, input logic [7:0] seed, input logic [47:0] dest,
                            input bit err, input bit eof_en);
    for (int i = 0; i < len; i++) begin
      rx_vld = 1'b1;
      rx_dat = gen_byte(dest, seed, i);
      rx_sof = (i == 0);
      rx_eof = eof_en && (i == len - 1);
      rx_err = err && (i == len - 1);
      @(posedge clk_mac);
      #1;
    end
    rx_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (cap_q.size() < n && t < 20000) begin
      @(posedge clk_mac);
      t++;
    end
    #1;
  endtask

  task automatic check_frame(input string tag, input int len, input logic [7:0] seed,
                             input logic [47:0] dest);
    int   bad = 0;
    cap_t c;
    wait_bytes(len);
    chk({tag, "_avail"}, cap_q.size() >= len, 1);
    for (int i = 0; i < len && cap_q.size() > 0; i++) begin
      c = cap_q.pop_front();
      if (c.d != gen_byte(dest, seed, i) || c.s != (i == 0) || c.e != (i == len - 1) ||
          c.l != 11'(len)) bad++;
    end
    chk({tag, "_bytes"}, bad, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rx_vld = 0; rx_dat = 0; rx_sof = 0; rx_eof = 0; rx_err = 0; out_ack = 0;
    idle(3);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    idle(2);

    // good 64-byte broadcast frame, consumer always ready
    out_ack = 1'b1;
    send_frame(64, 8'h01, BCAST, 0, 1);
    lat = 0;
    while (!out_vld && lat < 10) begin
      @(posedge clk_mac);
      #1;
      lat++;
    end
    chk("first_byte_latency_le3", lat <= 3, 1);
    check_frame("f64", 64, 8'h01, BCAST);
    chk("drop_after_good", drop_cnt, 0);

    // errored frame discarded, following frame intact
    send_frame(64, 8'h02, BCAST, 1, 1);
    send_frame(60, 8'h03, BCAST, 0, 1);
    check_frame("f60", 60, 8'h03, BCAST);
    idle(200);
    chk("err_no_extra", cap_q.size(), 0);
    chk("drop_after_err", drop_cnt, 1);

    // consumer stalled: four descriptors fit, the fifth frame is dropped
    out_ack = 1'b0;
    for (int k = 0; k < 5; k++) send_frame(64, 8'(8'h10 + k), BCAST, 0, 1);
    idle(5);
    chk("stall_vld", out_vld, 1);
    chk("stall_sof", out_sof, 1);
    chk("stall_len", out_len, 64);
    chk("stall_dat", out_dat, 8'hff);
    chk("stall_no_accept", cap_q.size(), 0);
    chk("drop_desc_full", drop_cnt, 2);
    idle(20);
    chk("stall_hold_vld", out_vld, 1);
    out_ack = 1'b1;
    for (int k = 0; k < 4; k++) check_frame($sformatf("fstall%0d", k), 64, 8'(8'h10 + k), BCAST);
    idle(200);
    chk("stall_no_extra", cap_q.size(), 0);

    // length boundary: 1518 kept, 1519 dropped
    send_frame(1518, 8'h50, BCAST, 0, 1);
    check_frame("f1518", 1518, 8'h50, BCAST);
    chk("drop_after_1518", drop_cnt, 2);
    send_frame(1519, 8'h51, BCAST, 0, 1);
    idle(200);
    chk("f1519_not_emitted", cap_q.size(), 0);
    chk("drop_after_1519", drop_cnt, 3);

    // missing eof: partial discarded, new sof starts a good frame
    send_frame(20, 8'h60, BCAST, 0, 0);
    send_frame(30, 8'h61, BCAST, 0, 1);
    check_frame("frestart", 30, 8'h61, BCAST);
    chk("drop_after_restart", drop_cnt, 4);

    // oversize frame dropped, next frame intact
    send_frame(1600, 8'h70, BCAST, 0, 1);
    send_frame(64, 8'h71, BCAST, 0, 1);
    check_frame("f_after_1600", 64, 8'h71, BCAST);
    idle(200);
    chk("oversize_no_extra", cap_q.size(), 0);
    chk("drop_after_1600", drop_cnt, 5);

    // reset mid-frame with a committed frame pending
    out_ack = 1'b0;
    send_frame(64, 8'h80, BCAST, 0, 1);
    idle(4);
    chk("pend_vld", out_vld, 1);
    send_frame(30, 8'h81, BCAST, 0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(10);
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    cap_q.delete();
    out_ack = 1'b1;
    send_frame(64, 8'h82, BCAST, 0, 1);
    check_frame("f_after_rst", 64, 8'h82, BCAST);
    idle(200);
    chk("rst_no_extra", cap_q.size(), 0);

`ifdef RX_ADDR_FILTER_EN
    send_frame(64, 8'h90, 48'h020000000002, 0, 1);
    send_frame(64, 8'h91, 48'h020000000001, 0, 1);
    check_frame("f_filter_ok", 64, 8'h91, 48'h020000000001);
    idle(200);
    chk("filter_no_extra", cap_q.size(), 0);
    chk("filter_drop_cnt", drop_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/eth_rx_fifo.md
ETH_RX_FIFO -- requirements
Module: eth_rx_fifo

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, byte-RAM address width (2^ADDR_W bytes of frame storage).
REQ-002 SHALL have parameter LEN_DEPTH_W, default 2, log2 of frame-descriptor FIFO depth (4 frames).
REQ-003 SHALL have parameter MAC_ADDR, default 48'h000000000000, station address used by the filter.
REQ-004 SHALL have ports: clk_mac  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: rx_vld/rx_dat/rx_sof/rx_eof/rx_err  in  1/8/1/1/1  MAC receive byte stream; sof, eof, err qualified by rx_vld; err meaningful only with eof.
REQ-007 SHALL have ports: out_vld/out_dat/out_sof/out_eof  out  1/8/1/1  buffered frame byte stream.
REQ-008 SHALL have ports: out_len  out  11  byte count of the current output frame, valid while out_vld.
REQ-009 SHALL have ports: out_ack  in  1  consumer accepts the presented byte.
REQ-010 SHALL have ports: drop_cnt  out  16  saturating count of discarded frames.

Function
REQ-011 SHALL implement a write FSM with states W_IDLE, W_STORE, W_DROP.
REQ-012 W_IDLE: rx_vld&rx_sof SHALL latch the frame start pointer, write the byte, zero the byte count, enter W_STORE; other bytes ignored.
REQ-013 W_STORE: each rx_vld byte SHALL be written at wr_ptr, wr_ptr and count incremented modulo 2^ADDR_W.
REQ-014 rx_eof with rx_err=0 SHALL commit: push {start_ptr, count} into the descriptor FIFO in the same cycle, return to W_IDLE.
REQ-015 rx_eof with rx_err=1 SHALL rewind wr_ptr to start_ptr, increment drop_cnt, return to W_IDLE.
REQ-016 A byte write that would make wr_ptr equal to the oldest uncommitted-read pointer (RAM full) SHALL rewind wr_ptr, enter W_DROP.
REQ-017 Count exceeding 1518 bytes SHALL enter W_DROP with rewind.
REQ-018 A commit with descriptor FIFO full SHALL discard the frame as in REQ-015.
REQ-019 W_DROP SHALL ignore bytes until rx_eof, then increment drop_cnt once and enter W_IDLE.
REQ-020 rx_sof in W_STORE (missing eof) SHALL discard the partial frame, increment drop_cnt, and restart storage with that byte as the new frame start.
REQ-021 drop_cnt SHALL saturate at 16'hffff.
REQ-022 SHALL implement a read FSM with states R_IDLE, R_FETCH, R_SEND.
REQ-023 R_IDLE: non-empty descriptor FIFO SHALL load rd_ptr and remaining count, enter R_FETCH.
REQ-024 R_FETCH: synchronous RAM read, one cycle, then R_SEND with out_vld=1.
REQ-025 R_SEND: out_dat/out_sof/out_eof/out_len SHALL hold stable until out_ack; out_sof on first byte, out_eof on last.
REQ-026 out_ack on a non-last byte SHALL advance rd_ptr and return to R_FETCH (out_vld=0 one cycle); on the last byte SHALL pop the descriptor, free its RAM space, enter R_IDLE.
REQ-027 Simultaneous commit and pop SHALL both take effect; descriptor occupancy unchanged.
REQ-028 out_ack while out_vld=0 SHALL be ignored.
REQ-029 Latency: first byte of a committed frame SHALL appear on out_vld no later than 3 cycles after the commit cycle when the reader is idle.

Reset
REQ-030 rst SHALL force W_IDLE, R_IDLE, all pointers 0, descriptor FIFO empty, drop_cnt 0, out_vld/out_sof/out_eof 0, out_dat 0, out_len 0.
REQ-031 rst mid-frame SHALL discard all stored and in-progress frames without incrementing drop_cnt; RAM contents need not be cleared.

Configuration
REQ-032 With RX_ADDR_FILTER_EN defined, bytes 0-5 SHALL be compared against MAC_ADDR and ff:ff:ff:ff:ff:ff; a mismatch by byte 5 SHALL enter W_DROP and count as a drop.
REQ-033 Without RX_ADDR_FILTER_EN, all error-free frames SHALL be stored; MAC_ADDR is unused.

Verification
REQ-034 64-byte frame, dest ff:ff:ff:ff:ff:ff, err=0, out_ack tied 1 -> 64 bytes out identical, out_len=64, sof on byte 0, eof on byte 63, drop_cnt=0.
REQ-035 64-byte frame with rx_err=1 on eof, then a 60-byte good frame -> only the 60-byte frame emitted, drop_cnt=1.
REQ-036 out_ack held 0, five 64-byte good frames -> four emitted after out_ack released, drop_cnt=1.
REQ-037 1600-byte frame -> not emitted, drop_cnt=1; following 64-byte frame emitted intact.
REQ-038 rst pulsed at byte 30 of a frame with one committed frame pending -> out_vld=0, drop_cnt=0, next frame emitted normally.
REQ-039 With RX_ADDR_FILTER_EN, MAC_ADDR=48'h02_00_00_00_00_01: dest 02:00:00:00:00:02 -> dropped, drop_cnt=1; dest 02:00:00:00:00:01 -> emitted.
